// File: rtl/wbu.sv
// -----------------------------------------------------------------------------
// wbu -- write-back unit
//
// Holds one retiring entry from the MEM stage in a holding register. When the
// entry commits, it is written into a 2^REG_ADDR_WIDTH x DATA_WIDTH register
// file. Decode reads that register file through two bypassed ports.
// Handshake: an entry transfers in when mem_to_wb_valid & wb_to_mem_ready.
// While nothing stalls, one entry moves in and one retires on every cycle.
//
// Ports
//   clk               single clock, rising edge
//   rst               asynchronous active-low reset
//   mem_to_wb_valid   MEM presents a valid entry
//   wb_to_mem_ready   this block can accept an entry this cycle
//   mem_to_wb_bus     {regW, regAddr, regData}
//   wb_hold           external stall; blocks commit
//   rs1_addr/rs2_addr decode read addresses
//   rs1_data/rs2_data decode read data (bypassed from the committing entry)
//   commit_valid      an entry retires this cycle
//   commit_we/rd/data fields of the held entry
//   retire_cnt        number of retired entries, wraps at 2^32
// -----------------------------------------------------------------------------
module wbu #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mem_to_wb_valid,
    output logic                               wb_to_mem_ready,
    input  logic [DATA_WIDTH+REG_ADDR_WIDTH:0] mem_to_wb_bus,
    input  logic                               wb_hold,
    input  logic [REG_ADDR_WIDTH-1:0]          rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]          rs2_addr,
    output logic [DATA_WIDTH-1:0]              rs1_data,
    output logic [DATA_WIDTH-1:0]              rs2_data,
    output logic                               commit_valid,
    output logic                               commit_we,
    output logic [REG_ADDR_WIDTH-1:0]          commit_rd,
    output logic [DATA_WIDTH-1:0]              commit_data,
    output logic [31:0]                        retire_cnt
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    // Holding register and its qualifier
    logic                      wb_valid_q, wb_valid_d;
    logic                      wb_we_q,    wb_we_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q,    wb_rd_d;
    logic [DATA_WIDTH-1:0]     wb_data_q,  wb_data_d;
    logic [31:0]               retire_cnt_q, retire_cnt_d;

    logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];

    logic transfer;
    logic commit;
    logic reg_write;

    // Bus fields
    logic                      bus_we;
    logic [REG_ADDR_WIDTH-1:0] bus_rd;
    logic [DATA_WIDTH-1:0]     bus_data;

    assign bus_we   = mem_to_wb_bus[DATA_WIDTH+REG_ADDR_WIDTH];
    assign bus_rd   = mem_to_wb_bus[DATA_WIDTH +: REG_ADDR_WIDTH];
    assign bus_data = mem_to_wb_bus[DATA_WIDTH-1:0];

    // When the held entry commits, the slot frees up in the same cycle. This
    // keeps throughput at one entry per cycle.
    assign wb_to_mem_ready = ~wb_valid_q | ~wb_hold;
    assign commit          = wb_valid_q & ~wb_hold;
    assign transfer        = mem_to_wb_valid & wb_to_mem_ready;
    assign reg_write       = commit & wb_we_q & (wb_rd_q != '0);

    assign commit_valid = commit;
    assign commit_we    = wb_we_q;
    assign commit_rd    = wb_rd_q;
    assign commit_data  = wb_data_q;
    assign retire_cnt   = retire_cnt_q;

    // NOTE: each output is given a default value at the top of the block, so no latch is inferred.
    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_we_d      = wb_we_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        retire_cnt_d = retire_cnt_q;

        if (commit) begin
            wb_valid_d   = 1'b0;
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
        // A transfer on the same cycle as a commit overrides the clear above.
        if (transfer) begin
            wb_valid_d = 1'b1;
            wb_we_d    = bus_we;
            wb_rd_d    = bus_rd;
            wb_data_d  = bus_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // NOTE: the register file must read zero straight after reset, so it is built from resettable flops and not from RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_write) begin
            regs_q[wb_rd_q] <= wb_data_q;
        end
    end

    // Read port: x0 is hard zero. Otherwise the committing entry is forwarded
    // ahead of its own write edge.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REG_ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        if (addr == '0) begin
            value = '0;
        end else if (commit && wb_we_q && (wb_rd_q == addr)) begin
            value = wb_data_q;
        end else begin
            value = regs_q[addr];
        end
        return value;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

endmodule

// File: tb/tb_wbu.sv
// -----------------------------------------------------------------------------
// tb_wbu -- self-checking bench for wbu
//
// A behavioural reference model holds the following:
//   - one optional "pending" entry,
//   - an array of architectural registers,
//   - a retire counter.
// The model steps through the stated transfer/commit rules once per clock.
// Directed scenarios come first. Randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_wbu;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          mem_to_wb_valid;
    logic          wb_to_mem_ready;
    logic [DW+AW:0] mem_to_wb_bus;
    logic          wb_hold;
    logic [AW-1:0] rs1_addr, rs2_addr;
    logic [DW-1:0] rs1_data, rs2_data;
    logic          commit_valid, commit_we;
    logic [AW-1:0] commit_rd;
    logic [DW-1:0] commit_data;
    logic [31:0]   retire_cnt;

    wbu #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_to_wb_valid (mem_to_wb_valid),
        .wb_to_mem_ready (wb_to_mem_ready),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .wb_hold         (wb_hold),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .commit_valid    (commit_valid),
        .commit_we       (commit_we),
        .commit_rd       (commit_rd),
        .commit_data     (commit_data),
        .retire_cnt      (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          we;
        bit [AW-1:0] rd;
        bit [DW-1:0] data;
    } entry_t;

    entry_t      pending[$];       // at most one element
    bit [DW-1:0] arch_regs [32];
    bit [31:0]   retired;

    task automatic model_reset();
        pending.delete();
        foreach (arch_regs[i]) arch_regs[i] = '0;
        retired = 0;
    endtask

    function automatic bit [DW-1:0] model_read(input bit [AW-1:0] a, input bit retiring);
        if (a == 0) return '0;
        if (retiring && pending[0].we && pending[0].rd == a) return pending[0].data;
        return arch_regs[a];
    endfunction

    // Drive one cycle and check all combinational outputs mid-cycle. Then
    // advance the model across the rising edge.
    task automatic cycle(input bit v, input bit w, input bit [AW-1:0] rd, input bit [DW-1:0] d,
                         input bit h, input bit [AW-1:0] a1, input bit [AW-1:0] a2);
        bit retiring;
        bit accept;
        @(negedge clk);
        mem_to_wb_valid = v;
        mem_to_wb_bus   = {w, rd, d};
        wb_hold         = h;
        rs1_addr        = a1;
        rs2_addr        = a2;
        #1;
        retiring = (pending.size() == 1) && !h;
        accept   = (pending.size() == 0) || !h;
        check("ready",        32'(wb_to_mem_ready), 32'(accept));
        check("commit_valid", 32'(commit_valid),    32'(retiring));
        if (pending.size() == 1) begin
            check("commit_we",   32'(commit_we),   32'(pending[0].we));
            check("commit_rd",   32'(commit_rd),   32'(pending[0].rd));
            check("commit_data", commit_data,      pending[0].data);
        end
        check("rs1_data",   rs1_data,   model_read(a1, retiring));
        check("rs2_data",   rs2_data,   model_read(a2, retiring));
        check("retire_cnt", retire_cnt, retired);
        @(posedge clk);
        if (retiring) begin
            retired = retired + 1;
            if (pending[0].we && pending[0].rd != 0) arch_regs[pending[0].rd] = pending[0].data;
            void'(pending.pop_front());
        end
        if (v && accept) pending.push_back('{we: w, rd: rd, data: d});
    endtask

    task automatic idle(input bit [AW-1:0] a1, input bit [AW-1:0] a2);
        cycle(0, 0, 0, 32'h0, 0, a1, a2);
    endtask

    initial begin
        rst             = 1'b0;
        mem_to_wb_valid = 1'b0;
        mem_to_wb_bus   = '0;
        wb_hold         = 1'b0;
        rs1_addr        = '0;
        rs2_addr        = '0;
        model_reset();

        // Reset state
        #12;
        check("rst_ready",  32'(wb_to_mem_ready), 32'd1);
        check("rst_commit", 32'(commit_valid),    32'd0);
        check("rst_rs1",    rs1_data,             32'd0);
        check("rst_cnt",    retire_cnt,           32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single transfer, one-cycle latency, then read back
        cycle(1, 1, 5, 32'h1234_5678, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 5, 0);
        check("d1_rd", 32'(commit_rd), 32'd5);
        idle(5, 0);
        check("d1_rs1", rs1_data,   32'h1234_5678);
        check("d1_cnt", retire_cnt, 32'd1);

        // Back-to-back transfers
        cycle(1, 1, 3, 32'h3333_0003, 0, 3, 4);
        cycle(1, 1, 4, 32'h4444_0004, 0, 3, 4);
        cycle(0, 0, 0, 32'h0, 0, 3, 4);
        idle(3, 4);
        check("b2b_cnt", retire_cnt, 32'd3);

        // Hold for three cycles with an entry present
        cycle(1, 1, 8, 32'h0808_0808, 0, 8, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 9, 32'hBAD0_0000, 1, 8, 0);
        check("hold_ready", 32'(wb_to_mem_ready), 32'd0);
        cycle(0, 0, 0, 32'h0, 0, 8, 0);
        idle(8, 9);
        check("hold_rs1", rs1_data, 32'h0808_0808);

        // Writes to x0 and entries with regW=0
        cycle(1, 1, 0, 32'hDEAD_BEEF, 0, 0, 0);
        cycle(1, 0, 7, 32'h0000_00AA, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 0, 7);
        idle(0, 7);
        check("x0_rs1", rs1_data, 32'd0);
        check("nowe_rs2", rs2_data, 32'd0);

        // Same-cycle bypass
        cycle(1, 1, 9, 32'h0000_0055, 0, 0, 9);
        cycle(0, 0, 0, 32'h0, 0, 0, 9);
        check("byp_rs2", rs2_data, 32'h0000_0055);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit [AW-1:0] rd;
            bit [AW-1:0] a1;
            bit [AW-1:0] a2;
            rd = AW'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? commit_rd : AW'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? commit_rd : AW'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rd, $urandom,
                  ($urandom_range(0, 9) < 3), a1, a2);
        end

        // Asynchronous reset between edges while an entry is about to commit
        cycle(1, 1, 6, 32'hCAFE_F00D, 1, 0, 0);
        @(negedge clk);
        mem_to_wb_valid = 1'b0;
        wb_hold         = 1'b0;
        rs1_addr        = 5'd6;
        rs2_addr        = 5'd5;
        #1;
        check("pre_rst_commit", 32'(commit_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_commit", 32'(commit_valid),    32'd0);
        check("arst_ready",  32'(wb_to_mem_ready), 32'd1);
        check("arst_cnt",    retire_cnt,           32'd0);
        check("arst_rs1",    rs1_data,             32'd0);
        check("arst_rs2",    rs2_data,             32'd0);
        @(posedge clk);
        #1;
        check("arst_hold_cnt", retire_cnt, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(6, 5);
        idle(6, 9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
